// File: rtl/ss_pkg.sv
// Shared types and constants for the score-display readback path.
// Seven-segment encoding: bit0=a .. bit6=g.
package ss_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h67;
    localparam logic [6:0] SEG_MASK = 7'h7F;

    typedef enum logic [1:0] {
        SETTLE,
        PRESENT,
        WAIT_CHANGE
    } ss_rd_state_t;

    typedef struct packed {
        logic [6:0] tens;
        logic [6:0] ones;
    } ss_pair_t;

endpackage

// File: rtl/ss_digit_dec.sv
// Exact-match seven-segment to BCD digit decoder; any non-digit pattern is illegal.
module ss_digit_dec
    import ss_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic [3:0] digit_o
);

    always_comb begin
        legal_o = 1'b1;
        digit_o = '0;
        case (seg_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ss_score_reader.sv
// Reads back the two-digit score display, debounces it and reports the binary score.
// Optional saturating error-handshake counter enabled by defining SS_ERRCNT_EN.
module ss_score_reader
    import ss_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_tens,
    input  logic [7:0] seg_ones,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [4:0] out_value,
    output logic       out_err
`ifdef SS_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int unsigned   CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    ss_rd_state_t  state_q;
    ss_pair_t      pair_d;
    ss_pair_t      samp_q;
    ss_pair_t      acc_q;
    logic          acc_vld_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic          valid_q;
    logic [4:0]    value_q;
    logic          err_q;

    logic          tens_ok;
    logic          ones_ok;
    logic [3:0]    tens_dig;
    logic [3:0]    ones_dig;
    logic [5:0]    val6;
    logic          bad_d;
    logic [4:0]    value_d;
    logic          unused_bit7;

    assign unused_bit7 = seg_tens[7] ^ seg_ones[7];

    ss_digit_dec u_dec_tens (
        .seg_i   (samp_q.tens),
        .legal_o (tens_ok),
        .digit_o (tens_dig)
    );

    ss_digit_dec u_dec_ones (
        .seg_i   (samp_q.ones),
        .legal_o (ones_ok),
        .digit_o (ones_dig)
    );

    // Tens above 3 always exceeds 31; checking it keeps the 6-bit sum from aliasing.
    always_comb begin
        pair_d.tens = seg_tens[6:0] & SEG_MASK;
        pair_d.ones = seg_ones[6:0] & SEG_MASK;
        cnt_inc     = cnt_q + 1'b1;
        val6        = {2'b00, tens_dig} * 6'd10 + {2'b00, ones_dig};
        bad_d       = !tens_ok || !ones_ok || (tens_dig > 4'd3) || (val6 > 6'd31);
        value_d     = bad_d ? '0 : val6[4:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SETTLE;
            samp_q    <= '0;
            acc_q     <= '0;
            acc_vld_q <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            value_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            samp_q <= pair_d;
            case (state_q)
                SETTLE: begin
                    if (pair_d == samp_q) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_inc;
                        end
                        if (cnt_inc == CNT_MAX) begin
                            // A glitch that settles back onto the last accepted pair is not re-reported.
                            if (acc_vld_q && (pair_d == acc_q)) begin
                                cnt_q   <= '0;
                                state_q <= WAIT_CHANGE;
                            end else begin
                                valid_q   <= 1'b1;
                                value_q   <= value_d;
                                err_q     <= bad_d;
                                acc_q     <= samp_q;
                                acc_vld_q <= 1'b1;
                                state_q   <= PRESENT;
                            end
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= WAIT_CHANGE;
                    end
                end
                WAIT_CHANGE: begin
                    if (pair_d != acc_q) begin
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                default: begin
                    state_q <= SETTLE;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_value = value_q;
    assign out_err   = err_q;

`ifdef SS_ERRCNT_EN
    logic [7:0] err_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (valid_q && out_ready && err_q && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_ss_score_reader.sv
// Directed bench for ss_score_reader: vector table plus hand-written multi-cycle sequences.
module tb_ss_score_reader;

    logic       clk;
    logic       rst;
    logic [7:0] seg_tens;
    logic [7:0] seg_ones;
    logic       out_ready;
    logic       out_valid;
    logic [4:0] out_value;
    logic       out_err;

    logic [7:0] sw_tens;
    logic [7:0] sw_ones;
    logic       sw_ready;
    logic       v1_valid;
    logic [4:0] v1_value;
    logic       v1_err;
    logic       v255_valid;
    logic [4:0] v255_value;
    logic       v255_err;

`ifdef SS_ERRCNT_EN
    logic [7:0] err_count;
    logic [7:0] ec1;
    logic [7:0] ec255;
`endif

    int n_checks;
    int n_fail;

    ss_score_reader #(.STABLE_CYCLES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .seg_tens  (seg_tens),
        .seg_ones  (seg_ones),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_value (out_value),
        .out_err   (out_err)
`ifdef SS_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    ss_score_reader #(.STABLE_CYCLES(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .seg_tens  (sw_tens),
        .seg_ones  (sw_ones),
        .out_ready (sw_ready),
        .out_valid (v1_valid),
        .out_value (v1_value),
        .out_err   (v1_err)
`ifdef SS_ERRCNT_EN
        ,
        .err_count (ec1)
`endif
    );

    ss_score_reader #(.STABLE_CYCLES(255)) u_dut255 (
        .clk       (clk),
        .rst       (rst),
        .seg_tens  (sw_tens),
        .seg_ones  (sw_ones),
        .out_ready (sw_ready),
        .out_valid (v255_valid),
        .out_value (v255_value),
        .out_err   (v255_err)
`ifdef SS_ERRCNT_EN
        ,
        .err_count (ec255)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tens;
        logic [7:0] ones;
        logic [4:0] exp_value;
        logic       exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[15];
    int   exp_errs;
    int   seen;
    int   seen_val;
    int   bad;
    int   first1;
    int   first255;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_errs = 0;

        vecs[0]  = '{8'h5B, 8'h4F, 5'd23, 1'b0};
        vecs[1]  = '{8'h3F, 8'h3F, 5'd0,  1'b0};
        vecs[2]  = '{8'h4F, 8'h06, 5'd31, 1'b0};
        vecs[3]  = '{8'h4F, 8'h67, 5'd0,  1'b1};
        vecs[4]  = '{8'h4F, 8'h00, 5'd0,  1'b1};
        vecs[5]  = '{8'h06, 8'h5B, 5'd12, 1'b0};
        vecs[6]  = '{8'h86, 8'h06, 5'd11, 1'b0};
        vecs[7]  = '{8'h3F, 8'h67, 5'd9,  1'b0};
        vecs[8]  = '{8'h5B, 8'h3F, 5'd20, 1'b0};
        vecs[9]  = '{8'h4F, 8'h7F, 5'd0,  1'b1};
        vecs[10] = '{8'h66, 8'h3F, 5'd0,  1'b1};
        vecs[11] = '{8'h4F, 8'h3F, 5'd30, 1'b0};
        vecs[12] = '{8'h3F, 8'h7D, 5'd6,  1'b0};
        vecs[13] = '{8'h3F, 8'hED, 5'd5,  1'b0};
        vecs[14] = '{8'h5B, 8'h7C, 5'd0,  1'b1};

        // Reset state, then 23 held from reset release with ready high
        rst       = 1'b1;
        seg_tens  = 8'h5B;
        seg_ones  = 8'h4F;
        out_ready = 1'b1;
        sw_tens   = 8'h4F;
        sw_ones   = 8'h06;
        sw_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 0);
        check("reset_value", 32'(out_value), 0);
        check("reset_err",   32'(out_err),   0);
        #3 rst = 1'b0;

        bad = 0;
        for (int e = 1; e <= 4; e++) begin
            step();
            if (out_valid) bad = 1;
        end
        check("t1_settle_low", 32'(bad), 0);
        step();
        check("t1_valid", 32'(out_valid), 1);
        check("t1_value", 32'(out_value), 23);
        check("t1_err",   32'(out_err),   0);
        step();
        check("t1_accept_low", 32'(out_valid), 0);
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid) seen++;
        end
        check("t1_no_rereport", 32'(seen), 0);

        // Toggling ones digit never settles; then hold 01
        seg_tens = 8'h3F;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            seg_ones = (i % 2 == 0) ? 8'h06 : 8'h5B;
            repeat (3) begin
                step();
                if (out_valid) bad = 1;
            end
        end
        check("t2_toggle_quiet", 32'(bad), 0);
        seg_ones = 8'h06;
        seen     = 0;
        seen_val = -1;
        repeat (30) begin
            step();
            if (out_valid) begin
                seen++;
                seen_val = int'(out_value);
            end
        end
        check("t2_single_report", 32'(seen), 1);
        check("t2_value", 32'(seen_val), 1);

        // One-cycle glitch that returns to the accepted pair
        seg_ones = 8'h5B;
        step();
        seg_ones = 8'h06;
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid) seen++;
        end
        check("glitch_no_report", 32'(seen), 0);

        // Vector table: exact 5-edge latency from input change out of WAIT_CHANGE
        out_ready = 1'b0;
        foreach (vecs[i]) begin
            seg_tens = vecs[i].tens;
            seg_ones = vecs[i].ones;
            bad = 0;
            repeat (4) begin
                step();
                if (out_valid) bad = 1;
            end
            check($sformatf("v%0d_settle_low", i), 32'(bad), 0);
            step();
            check($sformatf("v%0d_valid", i), 32'(out_valid), 1);
            check($sformatf("v%0d_value", i), 32'(out_value), 32'(vecs[i].exp_value));
            check($sformatf("v%0d_err",   i), 32'(out_err),   32'(vecs[i].exp_err));
            if (vecs[i].exp_err) exp_errs++;
            out_ready = 1'b1;
            step();
            check($sformatf("v%0d_accept_low", i), 32'(out_valid), 0);
            out_ready = 1'b0;
        end
`ifdef SS_ERRCNT_EN
        check("err_count", 32'(err_count), 32'(exp_errs));
`endif

        // Back-pressure: 12 held while input moves to 30
        seg_tens = 8'h06;
        seg_ones = 8'h5B;
        repeat (5) step();
        check("bp_valid12", 32'(out_valid), 1);
        check("bp_value12", 32'(out_value), 12);
        seg_tens = 8'h4F;
        seg_ones = 8'h3F;
        bad = 0;
        repeat (10) begin
            step();
            if (!out_valid || out_value != 5'd12) bad = 1;
        end
        check("bp_hold12", 32'(bad), 0);
        out_ready = 1'b1;
        step();
        check("bp_accept_low", 32'(out_valid), 0);
        out_ready = 1'b0;
        bad = 0;
        repeat (4) begin
            step();
            if (out_valid) bad = 1;
        end
        check("bp_settle_low", 32'(bad), 0);
        step();
        check("bp_valid30", 32'(out_valid), 1);
        check("bp_value30", 32'(out_value), 30);

        // Asynchronous reset while presenting 30
        step();
        #3 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_value", 32'(out_value), 0);
        check("arst_err",   32'(out_err),   0);
`ifdef SS_ERRCNT_EN
        check("arst_err_count", 32'(err_count), 0);
`endif
        #9 rst = 1'b0;
        bad = 0;
        repeat (4) begin
            step();
            if (out_valid) bad = 1;
        end
        check("arst_settle_low", 32'(bad), 0);
        step();
        check("arst_revalid", 32'(out_valid), 1);
        check("arst_revalue", 32'(out_value), 30);

        // STABLE_CYCLES=1 and 255 with constant 31
        #3 rst = 1'b1;
        #10 rst = 1'b0;
        first1   = 0;
        first255 = 0;
        for (int e = 1; e <= 300; e++) begin
            step();
            if (v1_valid && first1 == 0) first1 = e;
            if (v255_valid && first255 == 0) first255 = e;
        end
        check("sc1_latency",   32'(first1),   2);
        check("sc1_value",     32'(v1_value), 31);
        check("sc1_err",       32'(v1_err),   0);
        check("sc255_latency", 32'(first255), 256);
        check("sc255_value",   32'(v255_value), 31);
        check("sc255_err",     32'(v255_err),   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ss_score_reader.md
Name: ss_score_reader

Overview:
- Inverse of the score display path: samples the tens and ones seven-segment patterns driven toward the score display, waits for them to be stable, and decodes them back to a 5-bit binary score (0..31).
- Delivers the result over a valid/ready handshake to game-logic checkers and the verification monitor, and flags any illegal pattern pair.

Parameters:
- STABLE_CYCLES, 4, number of consecutive unchanged-sample edges required before a pattern pair is accepted; legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- seg_tens  input  8  tens-digit segment pattern; bit0=a .. bit6=g; bit7 ignored
- seg_ones  input  8  ones-digit segment pattern; same encoding
- out_ready  input  1  consumer accepts the result this cycle
- out_valid  output  1  result available
- out_value  output  5  decoded score
- out_err  output  1  pattern pair illegal or decoded value > 31

Behaviour:
- Reset: state SETTLE; sample registers, stable counter, out_valid, out_value and out_err are all 0. Reset is asynchronous and may assert in any state; the held result is discarded.
- Sampling: {seg_tens[6:0], seg_ones[6:0]} is registered every edge into samp_q. The counter cnt has width $clog2(STABLE_CYCLES+1).
- SETTLE:
  - If the current input equals samp_q, cnt increments (saturating at STABLE_CYCLES); otherwise cnt is cleared to 0.
  - When the increment makes cnt reach STABLE_CYCLES, the decode is loaded into the output registers, out_valid goes to 1 and the state becomes PRESENT.
  - Latency: for an input held constant from before edge k, out_valid is high after edge k+STABLE_CYCLES.
- Digit decode (7-bit pattern, exact match only): 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x67=9. Any other pattern is illegal.
- Value and error rules:
  - value = tens*10 + ones, computed at 6-bit width.
  - out_err=1 and out_value=0 if either digit is illegal or value > 31.
  - Otherwise out_err=0 and out_value=value[4:0].
- PRESENT:
  - out_valid, out_value and out_err are held constant regardless of input changes.
  - On an edge with out_ready=1, out_valid drops to 0 and the state becomes WAIT_CHANGE. The accepted pair is kept in acc_q.
  - out_ready=1 in the same cycle out_valid rises counts as acceptance on the next edge, not the current one.
- WAIT_CHANGE:
  - out_valid stays 0.
  - If the input differs from acc_q, cnt is cleared and the state becomes SETTLE.
  - If the input equals acc_q, the block stays in WAIT_CHANGE. The same score is never re-reported back to back.
- Glitches: any single-cycle deviation in SETTLE restarts the count. A glitch that returns to acc_q before settling does not produce a report.
- STABLE_CYCLES=1: one matching edge suffices.

Optional Feature:
- Macro: SS_ERRCNT_EN.
- Defined:
  - Adds output port err_count, 8 bits: a saturating count (stops at 255) of handshakes completed with out_err=1.
  - err_count resets to 0 and increments on the same edge that out_valid&out_ready completes with out_err=1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package ss_pkg:
  - localparams for the ten digit segment patterns (SEG_0..SEG_9) and SEG_MASK=7'h7F.
  - typedef enum logic [1:0] ss_rd_state_t {SETTLE, PRESENT, WAIT_CHANGE}.
  - typedef struct for the 14-bit pattern pair.
- Sub-module ss_digit_dec: combinational 7-bit pattern -> {legal, digit[3:0]}, instantiated twice (tens, ones).

Test Plan:
- Hold seg_tens=0x5B, seg_ones=0x4F (23) from reset release with out_ready=1 -> out_valid high exactly 4 edges after first sample, out_value=23, out_err=0, then out_valid low for 1+ cycles and no second report while input is unchanged.
- Toggle seg_ones between 0x06 and 0x5B every 3 cycles, then hold 0x06 with tens=0x3F -> no out_valid during toggling; after holding, single report of out_value=1.
- seg_tens=0x4F, seg_ones=0x67 (39) -> out_err=1, out_value=0. Then seg_ones=0x00 -> out_err=1. With SS_ERRCNT_EN, err_count=2 after both handshakes.
- out_ready=0 for 10 cycles while the input changes from 12 to 30 -> out_value stays 12 with out_valid high. On ready, 12 is accepted, followed by a report of 30 four edges after the WAIT_CHANGE -> SETTLE transition.
- Assert rst for 1 cycle in PRESENT -> out_valid, out_value and out_err go to 0 immediately (asynchronously); the same held input is re-reported after STABLE_CYCLES edges.
- Parameter sweep STABLE_CYCLES=1 and 255 with a constant 31 (0x4F/0x06) -> valid after exactly 1 and 255 edges respectively; value=31.
